// File: rtl/mmap_guard_pkg.sv
// Shared types for the mmap bus guard: FSM states, request bundle
// and the default error word returned on aborted accesses.
package mmap_guard_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mmap_req_t;

endpackage

// File: rtl/mmap_bus_guard.sv
// Registered mmap request slice with timeout watchdog and sticky error.
// Optional MMAP_GUARD_RANGE_EN rejects requests outside ADDR_LO..ADDR_HI.
module mmap_bus_guard
  import mmap_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF,
  parameter logic [31:0] ADDR_LO        = 32'h1000_0000,
  parameter logic [31:0] ADDR_HI        = 32'h1FFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        up_valid_i,
  input  logic [31:0] up_addr_i,
  input  logic [31:0] up_wdata_i,
  input  logic [3:0]  up_wstrb_i,
  output logic [31:0] up_rdata_o,
  output logic        up_ready_o,
  output logic        dn_valid_o,
  output logic [31:0] dn_addr_o,
  output logic [31:0] dn_wdata_o,
  output logic [3:0]  dn_wstrb_o,
  input  logic [31:0] dn_rdata_i,
  input  logic        dn_ready_i,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic        err_wr_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  mmap_req_t     r_req;
  logic          r_dn_valid;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_err_addr;
  logic          r_err_wr;

  logic          w_accept;
  logic          w_reject;
  logic          w_done;
  logic          w_tmo;
  logic          w_fault;
  logic [31:0]   w_flt_addr;
  logic          w_flt_wr;
  logic          w_out_rng;

`ifdef MMAP_GUARD_RANGE_EN
  assign w_out_rng = (up_addr_i < ADDR_LO) || (up_addr_i > ADDR_HI);
`else
  logic w_unused_rng;
  assign w_out_rng    = 1'b0;
  assign w_unused_rng = ^{ADDR_LO, ADDR_HI};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (up_valid_i) begin
          if (w_out_rng) begin
            w_reject    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // a response on the last budget cycle still counts as normal
        if (dn_ready_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fault    = w_reject | w_tmo;
  assign w_flt_addr = w_reject ? up_addr_i : r_req.addr;
  assign w_flt_wr   = w_reject ? |up_wstrb_i : |r_req.wstrb;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req      <= '0;
      r_dn_valid <= 1'b0;
      r_cnt      <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_req.addr  <= up_addr_i;
        r_req.wdata <= up_wdata_i;
        r_req.wstrb <= up_wstrb_i;
        r_dn_valid  <= 1'b1;
      end else if (w_done || w_tmo) begin
        r_dn_valid  <= 1'b0;
      end
      if (w_accept)                r_cnt <= '0;
      else if (r_state == S_WAIT)  r_cnt <= r_cnt + 1'b1;
      if (w_done)       r_rdata <= dn_rdata_i;
      else if (w_fault) r_rdata <= ERR_RDATA;
    end
  end

  // first fault is kept until cleared; a clear racing a fault re-arms it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_err_wr   <= 1'b0;
    end else if (w_fault) begin
      r_err <= 1'b1;
      if (!r_err || err_clr_i) begin
        r_err_addr <= w_flt_addr;
        r_err_wr   <= w_flt_wr;
      end
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign up_ready_o = (r_state == S_RESP);
  assign up_rdata_o = r_rdata;
  assign dn_valid_o = r_dn_valid;
  assign dn_addr_o  = r_req.addr;
  assign dn_wdata_o = r_req.wdata;
  assign dn_wstrb_o = r_req.wstrb;
  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;
  assign err_wr_o   = r_err_wr;

endmodule

// File: tb/tb_mmap_bus_guard.sv
// Directed bench for mmap_bus_guard with TIMEOUT_CYCLES=16.
// Build with MMAP_GUARD_RANGE_EN to also exercise address rejection.
module tb_mmap_bus_guard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_valid;
  logic [31:0] up_addr;
  logic [31:0] up_wdata;
  logic [3:0]  up_wstrb;
  logic [31:0] up_rdata_o;
  logic        up_ready_o;
  logic        dn_valid_o;
  logic [31:0] dn_addr_o;
  logic [31:0] dn_wdata_o;
  logic [3:0]  dn_wstrb_o;
  logic [31:0] dn_rdata;
  logic        dn_ready;
  logic        err_clr;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_wr_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmap_bus_guard #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .up_valid_i (up_valid),
    .up_addr_i  (up_addr),
    .up_wdata_i (up_wdata),
    .up_wstrb_i (up_wstrb),
    .up_rdata_o (up_rdata_o),
    .up_ready_o (up_ready_o),
    .dn_valid_o (dn_valid_o),
    .dn_addr_o  (dn_addr_o),
    .dn_wdata_o (dn_wdata_o),
    .dn_wstrb_o (dn_wstrb_o),
    .dn_rdata_i (dn_rdata),
    .dn_ready_i (dn_ready),
    .err_clr_i  (err_clr),
    .err_o      (err_o),
    .err_addr_o (err_addr_o),
    .err_wr_o   (err_wr_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cyc = cycles from request sample to up_ready; lat < 0 means no response
  task automatic run_acc(
    input  logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
    input  int lat, input logic [31:0] rd, input int clr_at,
    output int cyc, output int dvn,
    output logic [31:0] sa, output logic [31:0] sw, output logic [3:0] ss);
    up_valid = 1'b1;
    up_addr  = a;
    up_wdata = wd;
    up_wstrb = ws;
    dvn = 0;
    sa  = '0;
    sw  = '0;
    ss  = '0;
    tick();
    cyc = 1;
    while (!up_ready_o && cyc < 64) begin
      if (dn_valid_o) dvn++;
      if (cyc == 1) begin
        sa = dn_addr_o;
        sw = dn_wdata_o;
        ss = dn_wstrb_o;
      end
      dn_ready = (lat >= 0) && (cyc == 1 + lat);
      dn_rdata = dn_ready ? rd : 32'h0BAD_0BAD;
      err_clr  = (cyc == clr_at);
      tick();
      cyc++;
    end
    if (dn_valid_o) dvn++;
    dn_ready = 1'b0;
    err_clr  = 1'b0;
    up_valid = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          dvn;
    logic [31:0] sa;
    logic [31:0] sw;
    logic [3:0]  ss;

    rst_n    = 1'b0;
    up_valid = 1'b0;
    up_addr  = '0;
    up_wdata = '0;
    up_wstrb = '0;
    dn_rdata = '0;
    dn_ready = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    chk("rst_up_ready", up_ready_o, 0);
    chk("rst_dn_valid", dn_valid_o, 0);
    chk("rst_rdata", up_rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_addr", err_addr_o, 0);
    rst_n = 1'b1;
    tick();

    run_acc(32'h1000_0010, 0, 4'h0, 3, 32'h1234_5678, -1,
            cyc, dvn, sa, sw, ss);
    chk("rd_lat", cyc, 5);
    chk("rd_data", up_rdata_o, 32'h1234_5678);
    chk("rd_dv_cycles", dvn, 4);
    chk("rd_dn_addr", sa, 32'h1000_0010);
    chk("rd_err", err_o, 0);
    tick();
    chk("rd_pulse", up_ready_o, 0);
    chk("rd_hold", up_rdata_o, 32'h1234_5678);

    run_acc(32'h1000_2000, 32'hA5A5_5A5A, 4'b0011, 1, 32'h0, -1,
            cyc, dvn, sa, sw, ss);
    chk("wr_lat", cyc, 3);
    chk("wr_dn_addr", sa, 32'h1000_2000);
    chk("wr_dn_wdata", sw, 32'hA5A5_5A5A);
    chk("wr_dn_wstrb", ss, 4'b0011);
    chk("wr_err", err_o, 0);
    tick();
    chk("wr_pulse", up_ready_o, 0);

    run_acc(32'h1000_0020, 0, 4'h0, 0, 32'h0000_00AA, -1,
            cyc, dvn, sa, sw, ss);
    chk("min_lat", cyc, 2);
    chk("min_data", up_rdata_o, 32'h0000_00AA);
    tick();

    run_acc(32'h1000_3004, 0, 4'h0, -1, 32'h0, -1, cyc, dvn, sa, sw, ss);
    chk("to_lat", cyc, 17);
    chk("to_dv_cycles", dvn, 16);
    chk("to_data", up_rdata_o, 32'hDEAD_BEEF);
    chk("to_err", err_o, 1);
    chk("to_err_addr", err_addr_o, 32'h1000_3004);
    chk("to_err_wr", err_wr_o, 0);
    tick();
    dn_ready = 1'b1;
    dn_rdata = 32'h5555_5555;
    tick();
    dn_ready = 1'b0;
    chk("late_ready", up_ready_o, 0);
    chk("late_dv", dn_valid_o, 0);
    chk("late_data", up_rdata_o, 32'hDEAD_BEEF);

    run_acc(32'h1000_4008, 32'h1, 4'hF, -1, 32'h0, -1,
            cyc, dvn, sa, sw, ss);
    chk("to2_lat", cyc, 17);
    chk("to2_err", err_o, 1);
    chk("to2_keep_addr", err_addr_o, 32'h1000_3004);
    chk("to2_keep_wr", err_wr_o, 0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", err_o, 0);
    chk("clr_keep_addr", err_addr_o, 32'h1000_3004);

    run_acc(32'h1000_5000, 0, 4'h0, -1, 32'h0, -1, cyc, dvn, sa, sw, ss);
    chk("to3_err", err_o, 1);
    chk("to3_addr", err_addr_o, 32'h1000_5000);
    tick();
    run_acc(32'h1000_600C, 32'h2, 4'b1000, -1, 32'h0, 16,
            cyc, dvn, sa, sw, ss);
    chk("clrset_err", err_o, 1);
    chk("clrset_addr", err_addr_o, 32'h1000_600C);
    chk("clrset_wr", err_wr_o, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    run_acc(32'h1000_7000, 0, 4'h0, 15, 32'hCAFE_F00D, -1,
            cyc, dvn, sa, sw, ss);
    chk("edge_lat", cyc, 17);
    chk("edge_data", up_rdata_o, 32'hCAFE_F00D);
    chk("edge_err", err_o, 0);
    tick();

    up_valid = 1'b1;
    up_addr  = 32'h1000_8000;
    up_wstrb = 4'h0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", dn_valid_o, 0);
    chk("mid_rst_rdata", up_rdata_o, 0);
    chk("mid_rst_addr", dn_addr_o, 0);
    chk("mid_rst_err_addr", err_addr_o, 0);
    chk("mid_rst_err_wr", err_wr_o, 0);
    up_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_acc(32'h1000_9000, 0, 4'h0, 2, 32'h0F0F_1234, -1,
            cyc, dvn, sa, sw, ss);
    chk("post_rst_lat", cyc, 4);
    chk("post_rst_data", up_rdata_o, 32'h0F0F_1234);
    chk("post_rst_err", err_o, 0);
    tick();

`ifdef MMAP_GUARD_RANGE_EN
    run_acc(32'h2000_0000, 0, 4'h0, -1, 32'h0, -1, cyc, dvn, sa, sw, ss);
    chk("rng_lat", cyc, 1);
    chk("rng_dv_cycles", dvn, 0);
    chk("rng_data", up_rdata_o, 32'hDEAD_BEEF);
    chk("rng_err", err_o, 1);
    chk("rng_err_addr", err_addr_o, 32'h2000_0000);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
